hazard_scoreboard: RTL and testbench

// - Producer-side partner of the EX-stage forwarding logic. Sits at the ID stage of the 5-stage MIPS pipeline.
// - Tracks in-flight register writes in a per-register countdown scoreboard.
// - Stalls the instruction in ID while an operand cannot yet be forwarded: load-use, multi-cycle MUL result, MUL structural busy, WAW reorder.
// - Drives PC/IF-ID write enables and the ID/EX bubble.

---
 rtl/hazard_scoreboard.sv | 122 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage hazard detection for the 5-stage MIPS pipeline.
// Each architectural register has a countdown of cycles until its in-flight
// result can be forwarded to a reader in ID. A separate countdown tracks
// occupancy of the multi-cycle MUL unit.
// Optional feature: define HAZARD_STATS_EN to add the stall_cycles counter.
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int MUL_LAT  = 4,
    parameter int CW       = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_regWrite,
    input  logic [AW-1:0]   id_rd,
    input  logic [1:0]      id_kind,
    input  logic            flush,
    output logic            stall,
    output logic            pc_write,
    output logic            if_id_write,
    output logic            id_ex_bubble,
    output logic            mul_busy,
    output logic [NREG-1:0] pending
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]     stall_cycles
`endif
);

    localparam logic [1:0] KIND_LOAD = 2'b01;
    localparam logic [1:0] KIND_MUL  = 2'b10;

    // Cycles until a result of this kind is forwardable; reserved kind acts as ALU.
    function automatic logic [CW-1:0] lat_of(input logic [1:0] kind);
        case (kind)
            KIND_LOAD: lat_of = CW'(LOAD_LAT);
            KIND_MUL:  lat_of = CW'(MUL_LAT);
            default:   lat_of = '0;
        endcase
    endfunction

    logic [NREG-1:0][CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0]           mul_cnt_q, mul_cnt_d;
    logic                    mul_busy_q, mul_busy_d;
    logic [CW-1:0]           id_lat;
    logic                    raw_s, raw_t, hz_struct, waw, issue;

    // Hazard detection against the current scoreboard contents.
    always_comb begin
        id_lat    = lat_of(id_kind);
        raw_s     = id_use_rs && (id_rs != '0) && (cnt_q[id_rs] != '0);
        raw_t     = id_use_rt && (id_rt != '0) && (cnt_q[id_rt] != '0);
        hz_struct = (id_kind == KIND_MUL) && (mul_cnt_q != '0);
        // A younger write may only proceed once it cannot complete before the older one.
        waw       = id_regWrite && (id_rd != '0) && (cnt_q[id_rd] > id_lat);
        stall     = id_valid && (raw_s || raw_t || hz_struct || waw);
        issue     = id_valid && !stall && !flush && !rst;
    end

    assign pc_write     = ~stall;
    assign if_id_write  = ~stall;
    assign id_ex_bubble = stall | flush;
    assign mul_busy     = mul_busy_q;

    // Pending bit per register; register 0 never becomes pending.
    always_comb begin
        pending = '0;
        for (int r = 0; r < NREG; r++) pending[r] = (cnt_q[r] != '0);
    end

    // Countdown with saturation; an issuing write reloads its destination.
    always_comb begin
        cnt_d = '0;
        for (int r = 1; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : '0;
            if (issue && id_regWrite && (id_rd == AW'(r))) cnt_d[r] = id_lat;
        end
        mul_cnt_d = (mul_cnt_q != '0) ? mul_cnt_q - 1'b1 : '0;
        // MUL occupies the unit whether or not it writes a register.
        if (issue && (id_kind == KIND_MUL)) mul_cnt_d = CW'(MUL_LAT);
        mul_busy_d = (mul_cnt_d != '0);
    end

    // Scoreboard state; reset drops every in-flight entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            mul_cnt_q  <= '0;
            mul_busy_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            mul_cnt_q  <= mul_cnt_d;
            mul_busy_q <= mul_busy_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Count cycles lost to real stalls, not to squashed instructions.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && !flush && (stall_cycles_q != 32'hFFFF_FFFF))
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    // Stall statistics register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cycles_q <= '0;
        else     stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: expected ID-stage outputs are
// queued when each cycle's stimulus is driven and compared when sampled.
module tb_hazard_scoreboard;

    localparam logic [1:0] K_ALU = 2'b00;
    localparam logic [1:0] K_LD  = 2'b01;
    localparam logic [1:0] K_MUL = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_use_rs, id_use_rt, id_regWrite, flush;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [1:0]  id_kind;
    logic        stall, pc_write, if_id_write, id_ex_bubble, mul_busy;
    logic [31:0] pending;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
`endif

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_regWrite(id_regWrite),
        .id_rd(id_rd), .id_kind(id_kind), .flush(flush), .stall(stall),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
        .mul_busy(mul_busy), .pending(pending)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st, bb, pw, iw, bz;
        logic [31:0] pd;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] bit_of(input int r);
        return 32'd1 << r;
    endfunction

    function automatic void push_exp(input logic st, input logic bb, input logic bz,
                                     input logic [31:0] pd);
        exp_t x;
        x.st = st; x.bb = bb; x.pw = ~st; x.iw = ~st; x.bz = bz; x.pd = pd;
        sb.push_back(x);
    endfunction

    task automatic drive(input logic r, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic rw, input logic [4:0] rd,
                         input logic [1:0] k, input logic fl);
        @(negedge clk);
        rst = r; id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_regWrite = rw; id_rd = rd; id_kind = k; flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, K_ALU, 1'b0);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, K_MUL, 1'b1);
        push_exp(1'b0, 1'b1, 1'b0, 32'd0);
        #1; e = sb.pop_front(); checks++;
        if ({stall,id_ex_bubble,pc_write,if_id_write,mul_busy,pending} !== {e.st,e.bb,e.pw,e.iw,e.bz,e.pd}) begin
            errors++;
            $display("FAIL reset_flush: got st=%b bb=%b pw=%b iw=%b busy=%b pend=%h want st=%b bb=%b pw=%b iw=%b busy=%b pend=%h",
                     stall, id_ex_bubble, pc_write, if_id_write, mul_busy, pending, e.st, e.bb, e.pw, e.iw, e.bz, e.pd);
        end
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, K_MUL, 1'b0);
            else        idle();
            push_exp(1'b0, 1'b0, 1'b0, 32'd0);
            #1; e = sb.pop_front(); checks++;
            if ({stall,id_ex_bubble,pc_write,if_id_write,mul_busy,pending} !== {e.st,e.bb,e.pw,e.iw,e.bz,e.pd}) begin
                errors++;
                $display("FAIL reset c%0d: got st=%b bb=%b busy=%b pend=%h want st=%b bb=%b busy=%b pend=%h",
                         i, stall, id_ex_bubble, mul_busy, pending, e.st, e.bb, e.bz, e.pd);
            end
        end
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 4; i++) begin
            if (i == 0)      drive(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, K_LD, 1'b0);
            else if (i <= 2) drive(1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, K_ALU, 1'b0);
            else             idle();
            push_exp(i == 1, i == 1, 1'b0, (i == 1) ? bit_of(5) : 32'd0);
            #1; e = sb.pop_front(); checks++;
            if ({stall,id_ex_bubble,pc_write,if_id_write,mul_busy,pending} !== {e.st,e.bb,e.pw,e.iw,e.bz,e.pd}) begin
                errors++;
                $display("FAIL load_use c%0d: got st=%b bb=%b pw=%b busy=%b pend=%h want st=%b bb=%b pw=%b busy=%b pend=%h",
                         i, stall, id_ex_bubble, pc_write, mul_busy, pending, e.st, e.bb, e.pw, e.bz, e.pd);
            end
        end
    endtask

    task automatic test_alu_fwd();
        for (int i = 0; i < 3; i++) begin
            if (i == 0)      drive(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, K_ALU, 1'b0);
            else if (i == 1) drive(1'b0, 1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 5'd2, K_ALU, 1'b0);
            else             idle();
            push_exp(1'b0, 1'b0, 1'b0, 32'd0);
            #1; e = sb.pop_front(); checks++;
            if ({stall,id_ex_bubble,pc_write,if_id_write,mul_busy,pending} !== {e.st,e.bb,e.pw,e.iw,e.bz,e.pd}) begin
                errors++;
                $display("FAIL alu_fwd c%0d: got st=%b bb=%b busy=%b pend=%h want st=%b bb=%b busy=%b pend=%h",
                         i, stall, id_ex_bubble, mul_busy, pending, e.st, e.bb, e.bz, e.pd);
            end
        end
    endtask

    task automatic test_mul_struct();
        for (int i = 0; i < 11; i++) begin
            if (i == 0)      drive(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, K_MUL, 1'b0);
            else if (i <= 5) drive(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, K_MUL, 1'b0);
            else             idle();
            push_exp(i >= 1 && i <= 4, i >= 1 && i <= 4, (i >= 1 && i <= 4) || (i >= 6 && i <= 9),
                     (i >= 1 && i <= 4) ? bit_of(3) : (i >= 6 && i <= 9) ? bit_of(4) : 32'd0);
            #1; e = sb.pop_front(); checks++;
            if ({stall,id_ex_bubble,pc_write,if_id_write,mul_busy,pending} !== {e.st,e.bb,e.pw,e.iw,e.bz,e.pd}) begin
                errors++;
                $display("FAIL mul_struct c%0d: got st=%b bb=%b busy=%b pend=%h want st=%b bb=%b busy=%b pend=%h",
                         i, stall, id_ex_bubble, mul_busy, pending, e.st, e.bb, e.bz, e.pd);
            end
        end
    endtask

    task automatic test_waw();
        for (int i = 0; i < 7; i++) begin
            if (i == 0)      drive(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, K_MUL, 1'b0);
            else if (i <= 4) drive(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, K_LD, 1'b0);
            else             idle();
            push_exp(i >= 1 && i <= 3, i >= 1 && i <= 3, i >= 1 && i <= 4,
                     (i >= 1 && i <= 5) ? bit_of(9) : 32'd0);
            #1; e = sb.pop_front(); checks++;
            if ({stall,id_ex_bubble,pc_write,if_id_write,mul_busy,pending} !== {e.st,e.bb,e.pw,e.iw,e.bz,e.pd}) begin
                errors++;
                $display("FAIL waw c%0d: got st=%b bb=%b busy=%b pend=%h want st=%b bb=%b busy=%b pend=%h",
                         i, stall, id_ex_bubble, mul_busy, pending, e.st, e.bb, e.bz, e.pd);
            end
        end
    endtask

    task automatic test_r0();
        for (int i = 0; i < 4; i++) begin
            if (i == 0)      drive(1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, K_LD, 1'b0);
            else if (i <= 2) drive(1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, K_ALU, 1'b0);
            else             idle();
            push_exp(1'b0, 1'b0, 1'b0, 32'd0);
            #1; e = sb.pop_front(); checks++;
            if ({stall,id_ex_bubble,pc_write,if_id_write,mul_busy,pending} !== {e.st,e.bb,e.pw,e.iw,e.bz,e.pd}) begin
                errors++;
                $display("FAIL r0 c%0d: got st=%b bb=%b busy=%b pend=%h want st=%b bb=%b busy=%b pend=%h",
                         i, stall, id_ex_bubble, mul_busy, pending, e.st, e.bb, e.bz, e.pd);
            end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, K_LD, 1'b0);
                1: drive(1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, K_LD, 1'b1);
                2: drive(1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, K_ALU, 1'b0);
                3: drive(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6, K_LD, 1'b1);
                default: idle();
            endcase
            push_exp(i == 1, i == 1 || i == 3, 1'b0, (i == 1) ? bit_of(5) : 32'd0);
            #1; e = sb.pop_front(); checks++;
            if ({stall,id_ex_bubble,pc_write,if_id_write,mul_busy,pending} !== {e.st,e.bb,e.pw,e.iw,e.bz,e.pd}) begin
                errors++;
                $display("FAIL flush c%0d: got st=%b bb=%b busy=%b pend=%h want st=%b bb=%b busy=%b pend=%h",
                         i, stall, id_ex_bubble, mul_busy, pending, e.st, e.bb, e.bz, e.pd);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, K_MUL, 1'b0);
                1: idle();
                2: drive(1'b1, 1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, K_MUL, 1'b0);
                default: idle();
            endcase
            push_exp(1'b0, 1'b0, i == 1, (i == 1) ? bit_of(3) : 32'd0);
            #1; e = sb.pop_front(); checks++;
            if ({stall,id_ex_bubble,pc_write,if_id_write,mul_busy,pending} !== {e.st,e.bb,e.pw,e.iw,e.bz,e.pd}) begin
                errors++;
                $display("FAIL reset_mid c%0d: got st=%b bb=%b busy=%b pend=%h want st=%b bb=%b busy=%b pend=%h",
                         i, stall, id_ex_bubble, mul_busy, pending, e.st, e.bb, e.bz, e.pd);
            end
        end
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0;
        id_use_rt = 1'b0; id_regWrite = 1'b0; id_rd = '0; id_kind = K_ALU; flush = 1'b0;
        test_reset();
        test_load_use();
        test_alu_fwd();
        test_mul_struct();
        test_waw();
        test_r0();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
